// File: rtl/gb_io_pkg.sv
// Shared definitions for the Game Boy IO-register responders: bus addresses,
// serial-control constants and the serial link state encoding.
package gb_io_pkg;

    localparam logic [15:0] SB_ADDR        = 16'hFF01;
    localparam logic [15:0] SC_ADDR        = 16'hFF02;
    localparam logic [7:0]  SC_UNUSED_MASK = 8'h7E;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        EXT  = 2'd2
    } serial_state_e;

    // SC read image: unused bits 6..1 always read back as ones.
    function automatic logic [7:0] sc_read_value(input logic busy, input logic clk_sel);
        return SC_UNUSED_MASK | {busy, 6'b000000, clk_sel};
    endfunction

endpackage

// File: rtl/gb_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, followed by registered
// single-cycle rise/fall pulses (three clk cycles of lag from the pin).
module gb_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    // Synchronizer chain and edge pulses; reset to the pin's idle level so no edge is seen after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gb_serial_link.sv
// Game Boy serial link port: SB/SC bus responder, transfer FSM with internal
// clock divider or synchronized external clock, and a one-cycle completion irq.
module gb_serial_link
    import gb_io_pkg::*;
#(
    parameter int CLK_DIV = 512
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [7:0]  dataIn,
    input  logic        writeEnable,
    output logic [7:0]  dataOut,
    output logic        sel,
    input  logic        sckIn,
    input  logic        sin,
    output logic        sckOut,
    output logic        sckOe,
    output logic        sout,
    output logic        irq
);

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    serial_state_e    state_q, state_d;
    logic [7:0]       sb_q, sb_d;
    logic             clk_sel_q, clk_sel_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             sck_q, sck_d;
    logic             sout_q, sout_d;
    logic             irq_q, irq_d;
    logic             sck_oe_q;
    logic             sin_meta_q, sin_sync_q;

    logic busy_s;
    logic sb_wr_s;
    logic sc_wr_s;
    logic abort_s;
    logic shift_s;
    logic sck_rise_s;
    logic sck_fall_s;

    gb_sync_edge #(
        .RESET_VAL (1'b1)
    ) u_sck_sync (
        .clk_i  (clk),
        .rst_ni (rst),
        .d_i    (sckIn),
        .rise_o (sck_rise_s),
        .fall_o (sck_fall_s)
    );

    assign busy_s  = (state_q != IDLE);
    assign sb_wr_s = writeEnable && (addr == SB_ADDR);
    assign sc_wr_s = writeEnable && (addr == SC_ADDR);
    assign abort_s = busy_s && sc_wr_s && !dataIn[7];

    // Combinational read decode for the two serial registers.
    always_comb begin
        dataOut = 8'hFF;
        sel     = 1'b0;
        case (addr)
            SB_ADDR: begin
                dataOut = sb_q;
                sel     = 1'b1;
            end
            SC_ADDR: begin
                dataOut = sc_read_value(busy_s, clk_sel_q);
                sel     = 1'b1;
            end
            default: begin
                dataOut = 8'hFF;
                sel     = 1'b0;
            end
        endcase
    end

    // Transfer FSM, register writes, divider and bit counter next-state.
    always_comb begin
        state_d   = state_q;
        sb_d      = sb_q;
        clk_sel_d = clk_sel_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        sck_d     = sck_q;
        sout_d    = sout_q;
        irq_d     = 1'b0;
        shift_s   = 1'b0;

        if (sc_wr_s) begin
            clk_sel_d = dataIn[0];
        end else begin
            clk_sel_d = clk_sel_q;
        end

        case (state_q)
            IDLE: begin
                sck_d = 1'b1;
                if (sb_wr_s) begin
                    sb_d = dataIn;
                end else begin
                    sb_d = sb_q;
                end
                if (sc_wr_s && dataIn[7]) begin
                    state_d = dataIn[0] ? INT : EXT;
                    div_d   = DIV_ZERO;
                    cnt_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            INT: begin
                div_d = (div_q == DIV_LAST) ? DIV_ZERO : div_q + DIV_ONE;
                if (div_q == DIV_ZERO) begin
                    sck_d  = 1'b0;
                    sout_d = sb_q[7];
                end else if (div_q == DIV_HALF) begin
                    sck_d   = 1'b1;
                    shift_s = 1'b1;
                end else begin
                    sck_d = sck_q;
                end
            end
            EXT: begin
                sck_d = 1'b1;
                if (sck_fall_s) begin
                    sout_d = sb_q[7];
                end else if (sck_rise_s) begin
                    shift_s = 1'b1;
                end else begin
                    sout_d = sout_q;
                end
            end
            default: begin
                state_d = IDLE;
                sck_d   = 1'b1;
            end
        endcase

        // The eighth shift closes the transfer; sckOut is already high at this point.
        if (shift_s) begin
            sb_d  = {sb_q[6:0], sin_sync_q};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                state_d = IDLE;
                irq_d   = 1'b1;
                div_d   = DIV_ZERO;
            end else begin
                irq_d = 1'b0;
            end
        end else begin
            cnt_d = cnt_d;
        end

        if (abort_s) begin
            state_d = IDLE;
            sb_d    = sb_q;
            cnt_d   = 3'd0;
            div_d   = DIV_ZERO;
            sck_d   = 1'b1;
            irq_d   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sb_q      <= 8'h00;
            clk_sel_q <= 1'b0;
            cnt_q     <= 3'd0;
            div_q     <= DIV_ZERO;
            sck_q     <= 1'b1;
            sout_q    <= 1'b1;
            irq_q     <= 1'b0;
            sck_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sb_q      <= sb_d;
            clk_sel_q <= clk_sel_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sck_q     <= sck_d;
            sout_q    <= sout_d;
            irq_q     <= irq_d;
            sck_oe_q  <= (state_d == INT);
        end
    end

    // Serial data input synchronizer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sin_meta_q <= 1'b1;
            sin_sync_q <= 1'b1;
        end else begin
            sin_meta_q <= sin;
            sin_sync_q <= sin_meta_q;
        end
    end

    assign sckOut = sck_q;
    assign sckOe  = sck_oe_q;
    assign sout   = sout_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_gb_serial_link.sv
// Directed self-checking bench for gb_serial_link with CLK_DIV = 8.
module tb_gb_serial_link;

    localparam int CLK_DIV = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  dataIn = 8'h00;
    logic        writeEnable = 1'b0;
    logic [7:0]  dataOut;
    logic        sel;
    logic        sckIn = 1'b1;
    logic        sin = 1'b1;
    logic        sckOut;
    logic        sckOe;
    logic        sout;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // external-clock bookkeeping
    int ext_cyc;
    int ext_irq_n;
    int ext_irq_cyc;
    int ext_oe_bad;
    int ext_sck_bad;

    gb_serial_link #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst         (rst),
        .addr        (addr),
        .dataIn      (dataIn),
        .writeEnable (writeEnable),
        .dataOut     (dataOut),
        .sel         (sel),
        .sckIn       (sckIn),
        .sin         (sin),
        .sckOut      (sckOut),
        .sckOe       (sckOe),
        .sout        (sout),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a;
        dataIn = d;
        writeEnable = 1'b1;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
        addr = 16'h0000;
        dataIn = 8'h00;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic s);
        addr = a;
        #1;
        d = dataOut;
        s = sel;
        addr = 16'h0000;
    endtask

    task automatic watch(input int n, output int first_irq, output int n_irq);
        first_irq = -1;
        n_irq = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (irq) begin
                n_irq++;
                if (first_irq < 0) first_irq = k + 1;
            end
        end
    endtask

    task automatic ext_tick();
        @(posedge clk);
        ext_cyc++;
        @(negedge clk);
        if (sckOe !== 1'b0) ext_oe_bad++;
        if (sckOut !== 1'b1) ext_sck_bad++;
        if (irq === 1'b1) begin
            ext_irq_n++;
            ext_irq_cyc = ext_cyc;
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic s;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rd(16'hFF01, d, s);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_sb got %h exp 00", d); end
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL reset_sc got %h exp 7e", d); end
        checks++;
        if ({sckOut, sout, irq, sckOe} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_pins got sckOut=%b sout=%b irq=%b sckOe=%b exp 1 1 0 0", sckOut, sout, irq, sckOe);
        end
    endtask

    task automatic test_internal();
        logic [7:0] in_byte;
        logic [7:0] sout_bits;
        logic [7:0] d;
        logic s;
        logic prev_sck;
        logic fall_k1;
        int rises, first_rise, first_irq, n_irq;
        in_byte = 8'h3C;
        sout_bits = 8'h00;
        prev_sck = 1'b1;
        fall_k1 = 1'b1;
        rises = 0;
        first_rise = -1;
        first_irq = -1;
        n_irq = 0;
        wr(16'hFF01, 8'hA5);
        sin = in_byte[7];
        wr(16'hFF02, 8'h81);
        for (int k = 1; k <= 70; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) fall_k1 = sckOut;
            if (!sckOut && prev_sck && rises < 8) sin = in_byte[7 - rises];
            if (sckOut && !prev_sck) begin
                if (rises == 0) first_rise = k;
                sout_bits = {sout_bits[6:0], sout};
                rises++;
            end
            if (irq) begin
                n_irq++;
                if (first_irq < 0) first_irq = k + 1;
            end
            prev_sck = sckOut;
        end
        checks++; if (fall_k1 !== 1'b0) begin errors++; $display("FAIL int_first_fall sckOut=%b exp 0", fall_k1); end
        checks++; if (first_rise != 5) begin errors++; $display("FAIL int_first_rise edge %0d exp 5", first_rise); end
        checks++; if (rises != 8) begin errors++; $display("FAIL int_rises got %0d exp 8", rises); end
        checks++; if (sout_bits !== 8'hA5) begin errors++; $display("FAIL int_sout_bits got %h exp a5", sout_bits); end
        checks++; if (n_irq != 1) begin errors++; $display("FAIL int_irq_count got %0d exp 1", n_irq); end
        checks++; if (first_irq != 62) begin errors++; $display("FAIL int_irq_edge got %0d exp 62", first_irq); end
        rd(16'hFF01, d, s);
        checks++; if (d !== 8'h3C) begin errors++; $display("FAIL int_sb got %h exp 3c", d); end
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL int_sc got %h exp 7f", d); end
        checks++; if (sckOut !== 1'b1) begin errors++; $display("FAIL int_sck_idle got %b exp 1", sckOut); end
    endtask

    task automatic test_external();
        logic [7:0] d;
        logic s;
        int rise_cyc;
        sin = 1'b1;
        sckIn = 1'b1;
        ext_cyc = 0;
        ext_irq_n = 0;
        ext_irq_cyc = -1;
        ext_oe_bad = 0;
        ext_sck_bad = 0;
        rise_cyc = 0;
        wr(16'hFF02, 8'h80);
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'hFE) begin errors++; $display("FAIL ext_sc_busy got %h exp fe", d); end
        @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            sckIn = 1'b0;
            for (int c = 0; c < 10; c++) ext_tick();
            sckIn = 1'b1;
            rise_cyc = ext_cyc;
            for (int c = 0; c < 10; c++) ext_tick();
        end
        for (int c = 0; c < 6; c++) ext_tick();
        checks++; if (ext_oe_bad != 0) begin errors++; $display("FAIL ext_sckoe got %0d cycles high exp 0", ext_oe_bad); end
        checks++; if (ext_sck_bad != 0) begin errors++; $display("FAIL ext_sckout got %0d cycles low exp 0", ext_sck_bad); end
        checks++; if (ext_irq_n != 1) begin errors++; $display("FAIL ext_irq_count got %0d exp 1", ext_irq_n); end
        checks++;
        if (ext_irq_cyc - rise_cyc != 4) begin
            errors++;
            $display("FAIL ext_irq_lag got %0d exp 4", ext_irq_cyc - rise_cyc);
        end
        #1;
        rd(16'hFF01, d, s);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL ext_sb got %h exp ff", d); end
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL ext_sc got %h exp 7e", d); end
    endtask

    task automatic test_abort();
        logic [7:0] d;
        logic s;
        logic prev_sck;
        int rises, first_irq, n_irq;
        prev_sck = 1'b1;
        rises = 0;
        sin = 1'b1;
        wr(16'hFF02, 8'h81);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (sckOut && !prev_sck) rises++;
            prev_sck = sckOut;
            if (rises == 3) break;
        end
        checks++; if (rises != 3) begin errors++; $display("FAIL abort_reach got %0d shifts exp 3", rises); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (sckOut !== 1'b0) begin errors++; $display("FAIL abort_pre_sck got %b exp 0", sckOut); end
        wr(16'hFF02, 8'h01);
        checks++; if (sckOut !== 1'b1) begin errors++; $display("FAIL abort_sck got %b exp 1", sckOut); end
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'h7F) begin errors++; $display("FAIL abort_sc got %h exp 7f", d); end
        watch(80, first_irq, n_irq);
        checks++; if (n_irq != 0) begin errors++; $display("FAIL abort_irq got %0d pulses exp 0", n_irq); end
        wr(16'hFF02, 8'h81);
        watch(70, first_irq, n_irq);
        checks++; if (n_irq != 1) begin errors++; $display("FAIL restart_irq_count got %0d exp 1", n_irq); end
        checks++; if (first_irq != 62) begin errors++; $display("FAIL restart_irq_edge got %0d exp 62", first_irq); end
    endtask

    task automatic test_busy_reset();
        logic [7:0] d;
        logic s;
        int first_irq, n_irq;
        wr(16'hFF01, 8'hFF);
        sin = 1'b0;
        wr(16'hFF02, 8'h81);
        repeat (10) @(posedge clk);
        wr(16'hFF01, 8'h55);
        watch(70, first_irq, n_irq);
        checks++; if (n_irq != 1) begin errors++; $display("FAIL busy_irq_count got %0d exp 1", n_irq); end
        rd(16'hFF01, d, s);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL busy_sb got %h exp 00", d); end
        wr(16'hFF01, 8'hA5);
        wr(16'hFF02, 8'h81);
        repeat (20) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        rd(16'hFF01, d, s);
        checks++; if (d !== 8'h00) begin errors++; $display("FAIL rst_mid_sb got %h exp 00", d); end
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL rst_mid_sc got %h exp 7e", d); end
        checks++;
        if ({sckOut, sout, irq, sckOe} !== 4'b1100) begin
            errors++;
            $display("FAIL rst_mid_pins got sckOut=%b sout=%b irq=%b sckOe=%b exp 1 1 0 0", sckOut, sout, irq, sckOe);
        end
        @(negedge clk);
        rst = 1'b1;
        sin = 1'b1;
        watch(80, first_irq, n_irq);
        checks++; if (n_irq != 0) begin errors++; $display("FAIL rst_mid_irq got %0d pulses exp 0", n_irq); end
    endtask

    task automatic test_decode();
        logic [7:0] d;
        logic s;
        wr(16'hFF01, 8'hC3);
        rd(16'hFF03, d, s);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL dec_ff03_data got %h exp ff", d); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL dec_ff03_sel got %b exp 0", s); end
        rd(16'hFF01, d, s);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL dec_ff01_sel got %b exp 1", s); end
        wr(16'hFF00, 8'h81);
        repeat (3) @(posedge clk);
        #1;
        rd(16'hFF01, d, s);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL dec_wr_sb got %h exp c3", d); end
        rd(16'hFF02, d, s);
        checks++; if (d !== 8'h7E) begin errors++; $display("FAIL dec_wr_sc got %h exp 7e", d); end
        checks++; if (sckOe !== 1'b0) begin errors++; $display("FAIL dec_wr_sckoe got %b exp 0", sckOe); end
    endtask

    initial begin
        test_reset();
        test_internal();
        test_external();
        test_abort();
        test_busy_reset();
        test_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gb_serial_link.md
# gb_serial_link

Memory-mapped Game Boy serial link port: a CPU bus responder for SB (FF01) and SC (FF02) that shifts one byte out on `sout` while shifting one in from `sin`. The serial clock is either generated internally or taken from an external `sckIn`. It sits beside the other IO-register responders on the CPU bus inside the Gameboy top. On completion it raises a one-cycle serial interrupt request to the interrupt controller.

## Interface
- `CLK_DIV`, 512 — clk cycles per serial bit in internal-clock mode (8192 Hz at 4.194304 MHz); must be even and ≥4.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `addr`  in  16  CPU bus address.
- `dataIn`  in  8  CPU write data.
- `writeEnable`  in  1  CPU write strobe, sampled on the clk rising edge.
- `dataOut`  out  8  read data, combinational from `addr`.
- `sel`  out  1  `addr` is FF01 or FF02 (combinational).
- `sckIn`  in  1  external serial clock (asynchronous).
- `sin`  in  1  serial data in (asynchronous).
- `sckOut`  out  1  generated serial clock.
- `sckOe`  out  1  1 while in internal-clock mode and busy.
- `sout`  out  1  serial data out.
- `irq`  out  1  serial interrupt request, one-cycle pulse.

## Operation
- Reset values:
  - SB = 00; SC = 7E (bit7 = 0, bit0 = 0, bits 6..1 read 1).
  - `sckOut` = 1, `sout` = 1, `sckOe` = 0, `irq` = 0.
  - Bit counter = 0, divider = 0, state IDLE.
- Reads:
  - FF01 returns SB.
  - FF02 returns {busy, 6'b111111, clkSel}.
  - Any other address returns FF with `sel` = 0.
- Writes to SB are accepted only in IDLE; SB writes while busy are dropped.
- Writes to SC:
  - SC bit0 is always updated.
  - Bit7 = 1 from IDLE starts a transfer: INT if bit0 = 1, else EXT.
  - Bit7 = 0 while busy aborts: return to IDLE, no `irq`, counter cleared, `sckOut` = 1, SB keeps its partially shifted value.
- States:
  - IDLE: waits for a start.
  - INT: internal clock; divider runs 0..CLK_DIV-1.
    - At divider = 0: `sckOut` ← 0, `sout` ← SB[7].
    - At divider = CLK_DIV/2: `sckOut` ← 1, SB ← {SB[6:0], sin_sync}, counter++.
  - EXT: `sckIn` and `sin` pass through a 2-FF synchronizer, then edge detection.
    - Falling edge: `sout` ← SB[7].
    - Rising edge: shift as in INT, counter++.
- Completion, on the 8th shift edge:
  - SC bit7 ← 0, state ← IDLE.
  - `irq` = 1 for exactly the next cycle.
  - `sckOut` stays 1.
- Simultaneous events:
  - A CPU write to SB in the completion cycle is dropped, because busy is still 1.
  - An SC abort write in the completion cycle wins: no `irq`.
- `sckOut` is driven 1 in EXT and IDLE.
- Reset during a transfer clears everything immediately, with no `irq`.

## Timing
- CPU writes take effect at the clk edge on which `writeEnable` is sampled. Reads are combinational, with zero latency.
- INT mode, with the SC start write sampled at edge T:
  - `sckOut` falls at T+1.
  - First rising `sckOut` at T+1+CLK_DIV/2.
  - 8th shift at T+1+7·CLK_DIV+CLK_DIV/2.
  - `irq` high during the following cycle: 7·CLK_DIV+CLK_DIV/2+2 edges after T. This is 62 for CLK_DIV = 8.
- EXT mode:
  - Edge detection lags the `sckIn` pin by 3 clk cycles.
  - `irq` is high 3 cycles after the 8th rising `sckIn` is sampled, plus 1.
  - `sckIn` high and low times must each be ≥4 clk.
- Each transfer produces exactly one `irq` pulse. No pulse on abort or reset.

## Structure
- Shared package `gb_io_pkg`:
  - Address constants `SB_ADDR` = 16'hFF01 and `SC_ADDR` = 16'hFF02.
  - `SC_UNUSED_MASK` = 8'h7E.
  - State enum {IDLE, INT, EXT}.
- Sub-module `gb_sync_edge`: 2-FF synchronizer plus rise/fall pulse outputs, instantiated for `sckIn`. `sin` uses a plain 2-FF synchronizer of the same depth.
- Top-level is `gb_serial_link`: register file, FSM, divider, 3-bit counter.

## Test plan
All scenarios use CLK_DIV = 8.
- Reset → FF01 reads 00, FF02 reads 7E; `sckOut` = 1, `sout` = 1, `irq` = 0, `sckOe` = 0.
- Internal transfer: SB = A5, SC = 81, `sin` driving 3C MSB-first → `sout` bits 1,0,1,0,0,1,0,1; `irq` pulses once, 62 edges after the SC write; SB reads 3C; FF02 reads 7F.
- External transfer: SC = 80, 8 `sckIn` pulses of period 20, `sin` = 1 → SB = FF; `irq` once, 4 cycles after the 8th rising edge; `sckOe` = 0 throughout.
- Abort: start internal, write SC = 01 after 3 shifts → no `irq`, `sckOut` = 1, FF02 reads 7F. A new SC = 81 then completes in the full 62 edges.
- Busy protection and reset: an SB write of 55 mid-transfer is ignored; `rst` = 0 mid-transfer returns all registers to reset values immediately with no `irq`.
- Decode: reading FF03 → `dataOut` FF, `sel` = 0; writing FF00 leaves SB and SC unchanged.
